fwd_source_pipe: RTL and testbench
==================================

# fwd_source_pipe

Producer side of the operand-forwarding interface. Tracks the destination of every in-flight instruction through the EX, MEM and WB slots and drives the `rd_en_*`, `rd_addr_*`, `rd_data_*` and `ex_load_flag` buses consumed by the ID-stage hazard/forwarding logic. It also owns the 32×32 integer register file: it performs WB write-back and supplies `rs1_data_id` and `rs2_data_id`. It sits between the EX ALU, the data-memory read port and the ID stage.

## Interface
- `XLEN`, default 32: datapath width.
- `AW`, default 5: register address width.
- `clk` in 1: core clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rd_en`, `id_rd_addr[AW-1:0]`, `id_load_flag[4:0]` in: decoded destination and load type of the ID instruction.
- `id_rs1_addr`, `id_rs2_addr` in AW: register-file read addresses.
- `rs1_data_id`, `rs2_data_id` out XLEN: register-file read data.
- `ex_result` in XLEN: ALU result of the EX-slot instruction (combinational). For loads it is the byte address.
- `mem_rdata` in XLEN: aligned data-memory word for the MEM-slot load.
- `load_hazerd_stall` in 1: insert a bubble into EX and hold nothing else.
- `flush_ex` in 1: kill the instruction entering EX (taken branch/jump).
- `hold` in 1: freeze all slots (memory wait).
- `rd_en_ex`, `rd_addr_ex`, `rd_data_ex`, `ex_load_flag[4:0]` out: EX slot. `rd_data_ex` equals `ex_result`.
- `rd_en_mem`, `rd_addr_mem`, `rd_data_mem` out: MEM slot.
- `rd_en_wb`, `rd_addr_wb`, `rd_data_wb` out: WB slot.

## Operation
- **Load flag.** One-hot: bit0 LB, bit1 LH, bit2 LW, bit3 LBU, bit4 LHU. NO_LOAD is 5'b00000.
- **Slot contents.** Each slot holds en, addr, data and load flag. The EX slot has no data register, because its data is `ex_result`.
- **Advance priority per edge:** `rst_n` low, then `hold`, then `flush_ex`, then `load_hazerd_stall`, then normal.
  - Hold: all slots keep their value and no register-file write occurs.
  - Flush or stall: EX becomes a bubble (en=0, addr=0, flag=NO_LOAD). MEM and WB advance normally.
  - Normal: the EX slot captures the `id_*` inputs. MEM captures the EX slot plus `ex_result`. WB captures the MEM slot plus `rd_data_mem`.
- **x0.** A destination of 0 is never presented as valid: `rd_en_*` is forced to 0 when the slot address is 0.
- **MEM data.**
  - Non-load: the stored result.
  - Load: the lane is selected by the stored address `[1:0]` and then extended.
  - LB/LBU take byte `addr[1:0]`, sign- or zero-extended.
  - LH/LHU take the halfword at `addr[1]` (`addr[0]` is ignored), sign- or zero-extended.
  - LW takes the whole word.
- **Register file.**
  - Written at the edge with the WB slot when `rd_en_wb`=1 and no hold.
  - x0 reads 0 permanently.
  - Reads are combinational.
- **`ex_load_flag`** is output raw even when `rd_en_ex`=0.

## Timing
- **Reset.** Asynchronous. All slots are cleared: `rd_en_*`=0, `rd_addr_*`=0, `rd_data_mem`/`rd_data_wb`=0, `ex_load_flag`=NO_LOAD. All 32 registers are cleared to 0. Reset asserted mid-operation discards in-flight slots immediately.
- **Latency.** ID to EX visibility is 1 edge, ID to MEM is 2, ID to WB is 3. The register file shows the value 4 edges after ID capture, or in the WB cycle itself with bypass enabled.
- **Load data.** `mem_rdata` must be valid during the cycle the load occupies MEM. `rd_data_mem` is combinational from it.
- **Simultaneous events.**
  - `hold` overrides `flush_ex` and `load_hazerd_stall`.
  - With flush and stall together, a single bubble is inserted.
- **Back-to-back writes** to the same register: the later WB write wins at its edge, with no merging.

## Configuration
- **`FWD_SOURCE_WB_BYPASS_EN` defined:**
  - `rs1_data_id` returns `rd_data_wb` when `rd_en_wb`=1 and `id_rs1_addr`=`rd_addr_wb` (nonzero).
  - `rs2_data_id` behaves the same way against `id_rs2_addr`.
  - This gives write-through register-file reads.
- **Undefined:** reads return the stored array value only. The consumer's WB forwarding path covers the gap.

## Test plan
- **Reset.** Reset, then ID issues x5←0x1234 with no load. Required response: `rd_en_ex`=1/`rd_addr_ex`=5 after 1 edge, `rd_data_mem`=0x1234 after 2, `rd_data_wb`=0x1234 after 3, and reading x5 returns 0x1234 after 4.
- **LB sign-extend.** LB x7 with address 0x103 and `mem_rdata`=0x80FF_0000. Required response: `rd_data_mem`=0xFFFF_FF80.
- **LHU zero-extend.** LHU with address 0x102 and `mem_rdata`=0x8001_1234. Required response: `rd_data_mem`=0x0000_8001.
- **Stall bubble.** Assert `load_hazerd_stall` for 1 cycle while ID holds x3. Required response: the EX slot is a bubble for 1 cycle, MEM advances, and x3 enters EX on the next edge.
- **Hold mid-stream.** Assert `hold` for 3 cycles with all three slots full. Required response: all outputs remain stable and there is no register-file write. Flush during hold has no effect.
- **x0 and bypass.** Write x0←0xDEAD. Required response: `rd_en_*`=0 and x0 reads 0. With the macro defined, a same-cycle WB write of x9 and ID read of x9 returns the new value; without the macro it returns the old value.

Source files
------------

// File: rtl/fwd_source_pipe_if.sv
// Forwarding bus from the producer pipeline (EX/MEM/WB slots) to the
// ID-stage hazard/forwarding logic.
//   rd_en_*/rd_addr_*/rd_data_* : per-slot destination valid, address, data
//   ex_load_flag                : one-hot load type of the EX-slot instruction
// Modports: master = producer (fwd_source_pipe), slave = ID-stage consumer.
interface fwd_source_pipe_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic            rd_en_ex;
    logic [AW-1:0]   rd_addr_ex;
    logic [XLEN-1:0] rd_data_ex;
    logic [4:0]      ex_load_flag;
    logic            rd_en_mem;
    logic [AW-1:0]   rd_addr_mem;
    logic [XLEN-1:0] rd_data_mem;
    logic            rd_en_wb;
    logic [AW-1:0]   rd_addr_wb;
    logic [XLEN-1:0] rd_data_wb;

    modport master (
        output rd_en_ex, rd_addr_ex, rd_data_ex, ex_load_flag,
        output rd_en_mem, rd_addr_mem, rd_data_mem,
        output rd_en_wb, rd_addr_wb, rd_data_wb
    );

    modport slave (
        input rd_en_ex, rd_addr_ex, rd_data_ex, ex_load_flag,
        input rd_en_mem, rd_addr_mem, rd_data_mem,
        input rd_en_wb, rd_addr_wb, rd_data_wb
    );
endinterface

// File: rtl/fwd_source_pipe.sv
// Producer side of operand forwarding: tracks destinations through the
// EX/MEM/WB slots, extracts load data in MEM, and owns the integer
// register file (WB write-back, ID read ports).
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   id_rd_en/id_rd_addr/id_load_flag  : destination + load type of ID instr
//   id_rs1_addr/id_rs2_addr           : register-file read addresses
//   rs1_data_id/rs2_data_id           : register-file read data
//   ex_result                         : EX ALU result (byte address for loads)
//   mem_rdata                         : aligned memory word for the MEM load
//   load_hazerd_stall, flush_ex       : bubble into EX
//   hold                              : freeze every slot and the register file
//   fwd                               : forwarding bus (master)
// Option: define FWD_SOURCE_WB_BYPASS_EN for write-through register reads.
module fwd_source_pipe #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_rd_en,
    input  logic [AW-1:0]   id_rd_addr,
    input  logic [4:0]      id_load_flag,
    input  logic [AW-1:0]   id_rs1_addr,
    input  logic [AW-1:0]   id_rs2_addr,
    output logic [XLEN-1:0] rs1_data_id,
    output logic [XLEN-1:0] rs2_data_id,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            load_hazerd_stall,
    input  logic            flush_ex,
    input  logic            hold,
    fwd_source_pipe_if.master fwd
);
    localparam int unsigned NREGS = 1 << AW;
    localparam int unsigned FLAGW = 5;

    localparam logic [FLAGW-1:0] NO_LOAD = 5'b00000;
    localparam logic [FLAGW-1:0] LF_LB   = 5'b00001;
    localparam logic [FLAGW-1:0] LF_LH   = 5'b00010;
    localparam logic [FLAGW-1:0] LF_LW   = 5'b00100;
    localparam logic [FLAGW-1:0] LF_LBU  = 5'b01000;
    localparam logic [FLAGW-1:0] LF_LHU  = 5'b10000;

    logic             ex_en,   mem_en,   wb_en;
    logic [AW-1:0]    ex_addr, mem_addr, wb_addr;
    logic [FLAGW-1:0] ex_flag, mem_flag;
    logic [XLEN-1:0]  mem_data, wb_data;
    logic [XLEN-1:0]  mem_data_c;
    logic             wb_en_c;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [XLEN-1:0]  rf [NREGS];

    // Slot advance: hold freezes, flush/stall bubble EX only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_en    <= 1'b0;
            ex_addr  <= '0;
            ex_flag  <= NO_LOAD;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            mem_flag <= NO_LOAD;
            mem_data <= '0;
            wb_en    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (!hold) begin
            if (flush_ex || load_hazerd_stall) begin
                ex_en   <= 1'b0;
                ex_addr <= '0;
                ex_flag <= NO_LOAD;
            end else begin
                ex_en   <= id_rd_en;
                ex_addr <= id_rd_addr;
                ex_flag <= id_load_flag;
            end
            mem_en   <= ex_en;
            mem_addr <= ex_addr;
            mem_flag <= ex_flag;
            mem_data <= ex_result;
            wb_en    <= mem_en;
            wb_addr  <= mem_addr;
            wb_data  <= mem_data_c;
        end
    end

    // MEM data: stored result, or lane-selected and extended load data
    always_comb begin
        lane_b     = mem_rdata[{mem_data[1:0], 3'b000} +: 8];
        lane_h     = mem_rdata[{mem_data[1], 4'b0000} +: 16];
        mem_data_c = mem_data;
        case (mem_flag)
            LF_LB:   mem_data_c = {{(XLEN-8){lane_b[7]}}, lane_b};
            LF_LBU:  mem_data_c = {{(XLEN-8){1'b0}}, lane_b};
            LF_LH:   mem_data_c = {{(XLEN-16){lane_h[15]}}, lane_h};
            LF_LHU:  mem_data_c = {{(XLEN-16){1'b0}}, lane_h};
            LF_LW:   mem_data_c = mem_rdata;
            default: mem_data_c = mem_data;
        endcase
    end

    assign wb_en_c = wb_en && (wb_addr != '0);

    // Register file write-back; x0 is never written because wb_en_c masks it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf[i] <= '0;
            end
        end else if (!hold && wb_en_c) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Combinational read ports
    always_comb begin
        rs1_data_id = (id_rs1_addr == '0) ? '0 : rf[id_rs1_addr];
        rs2_data_id = (id_rs2_addr == '0) ? '0 : rf[id_rs2_addr];
`ifdef FWD_SOURCE_WB_BYPASS_EN
        if (wb_en_c && (id_rs1_addr == wb_addr)) begin
            rs1_data_id = wb_data;
        end
        if (wb_en_c && (id_rs2_addr == wb_addr)) begin
            rs2_data_id = wb_data;
        end
`endif
    end

    // Forwarding bus; a zero destination is never presented as valid
    assign fwd.rd_en_ex     = ex_en && (ex_addr != '0);
    assign fwd.rd_addr_ex   = ex_addr;
    assign fwd.rd_data_ex   = ex_result;
    assign fwd.ex_load_flag = ex_flag;
    assign fwd.rd_en_mem    = mem_en && (mem_addr != '0);
    assign fwd.rd_addr_mem  = mem_addr;
    assign fwd.rd_data_mem  = mem_data_c;
    assign fwd.rd_en_wb     = wb_en_c;
    assign fwd.rd_addr_wb   = wb_addr;
    assign fwd.rd_data_wb   = wb_data;
endmodule

// File: tb/tb_fwd_source_pipe.sv
// Directed bench for fwd_source_pipe: WB results come from a scoreboard
// filled at issue time; slot, load-extraction and register-file values
// are checked against constants.
module tb_fwd_source_pipe;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_exp_t;

    logic            clk;
    logic            rst_n;
    logic            id_rd_en;
    logic [AW-1:0]   id_rd_addr;
    logic [4:0]      id_load_flag;
    logic [AW-1:0]   id_rs1_addr;
    logic [AW-1:0]   id_rs2_addr;
    logic [XLEN-1:0] rs1_data_id;
    logic [XLEN-1:0] rs2_data_id;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] mem_rdata;
    logic            load_hazerd_stall;
    logic            flush_ex;
    logic            hold;

    int checks;
    int failures;
    wb_exp_t sb[$];

    fwd_source_pipe_if #(.XLEN(XLEN), .AW(AW)) fwd ();

    fwd_source_pipe #(.XLEN(XLEN), .AW(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rd_en          (id_rd_en),
        .id_rd_addr        (id_rd_addr),
        .id_load_flag      (id_load_flag),
        .id_rs1_addr       (id_rs1_addr),
        .id_rs2_addr       (id_rs2_addr),
        .rs1_data_id       (rs1_data_id),
        .rs2_data_id       (rs2_data_id),
        .ex_result         (ex_result),
        .mem_rdata         (mem_rdata),
        .load_hazerd_stall (load_hazerd_stall),
        .flush_ex          (flush_ex),
        .hold              (hold),
        .fwd               (fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [4:0] f);
        id_rd_en     = 1'b1;
        id_rd_addr   = a;
        id_load_flag = f;
    endtask

    task automatic idle_id();
        id_rd_en     = 1'b0;
        id_rd_addr   = '0;
        id_load_flag = 5'b00000;
    endtask

    task automatic check_wb(input string tag);
        wb_exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wb_en"},   32'(fwd.rd_en_wb),   32'd1);
            chk({tag, "_wb_addr"}, 32'(fwd.rd_addr_wb), 32'(e.addr));
            chk({tag, "_wb_data"}, fwd.rd_data_wb,      e.data);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b0;
        id_rd_en          = 1'b0;
        id_rd_addr        = '0;
        id_load_flag      = 5'b00000;
        id_rs1_addr       = '0;
        id_rs2_addr       = '0;
        ex_result         = '0;
        mem_rdata         = '0;
        load_hazerd_stall = 1'b0;
        flush_ex          = 1'b0;
        hold              = 1'b0;

        // Reset state
        #12;
        chk("rst_en_ex",   32'(fwd.rd_en_ex),     32'd0);
        chk("rst_addr_ex", 32'(fwd.rd_addr_ex),   32'd0);
        chk("rst_flag",    32'(fwd.ex_load_flag), 32'd0);
        chk("rst_en_mem",  32'(fwd.rd_en_mem),    32'd0);
        chk("rst_data_mem", fwd.rd_data_mem,      32'd0);
        chk("rst_en_wb",   32'(fwd.rd_en_wb),     32'd0);
        chk("rst_data_wb", fwd.rd_data_wb,        32'd0);
        id_rs1_addr = 5'd5;
        #1;
        chk("rst_rf_x5", rs1_data_id, 32'd0);
        rst_n = 1'b1;
        #1;

        // Basic latency: x5 <- 0x1234
        issue(5'd5, 5'b00000);
        sb.push_back('{addr: 5'd5, data: 32'h1234});
        step();
        idle_id();
        ex_result = 32'h1234;
        #1;
        chk("lat_en_ex",   32'(fwd.rd_en_ex),   32'd1);
        chk("lat_addr_ex", 32'(fwd.rd_addr_ex), 32'd5);
        chk("lat_data_ex", fwd.rd_data_ex,      32'h1234);
        step();
        ex_result = '0;
        #1;
        chk("lat_en_mem",   32'(fwd.rd_en_mem),   32'd1);
        chk("lat_addr_mem", 32'(fwd.rd_addr_mem), 32'd5);
        chk("lat_data_mem", fwd.rd_data_mem,      32'h1234);
        step();
        #1;
        check_wb("lat");
`ifdef FWD_SOURCE_WB_BYPASS_EN
        chk("lat_rf_wbcycle", rs1_data_id, 32'h1234);
`else
        chk("lat_rf_wbcycle", rs1_data_id, 32'd0);
`endif
        step();
        #1;
        chk("lat_rf_x5", rs1_data_id, 32'h1234);

        // LB x7 @0x103 then LHU x8 @0x102, back to back
        issue(5'd7, 5'b00001);
        sb.push_back('{addr: 5'd7, data: 32'hFFFF_FF80});
        step();
        issue(5'd8, 5'b10000);
        sb.push_back('{addr: 5'd8, data: 32'h0000_8001});
        ex_result = 32'h103;
        #1;
        chk("lb_flag_ex", 32'(fwd.ex_load_flag), 32'h01);
        chk("lb_addr_ex", 32'(fwd.rd_addr_ex),   32'd7);
        step();
        idle_id();
        ex_result = 32'h102;
        mem_rdata = 32'h80FF_0000;
        #1;
        chk("lb_data_mem", fwd.rd_data_mem,       32'hFFFF_FF80);
        chk("lhu_flag_ex", 32'(fwd.ex_load_flag), 32'h10);
        step();
        ex_result = '0;
        mem_rdata = 32'h8001_1234;
        #1;
        chk("lhu_data_mem", fwd.rd_data_mem, 32'h0000_8001);
        check_wb("lb");
        step();
        mem_rdata = '0;
        #1;
        check_wb("lhu");

        // Stall bubble: x2 ahead, x3 held in ID during a one-cycle stall
        issue(5'd2, 5'b00000);
        sb.push_back('{addr: 5'd2, data: 32'h22});
        step();
        issue(5'd3, 5'b00000);
        sb.push_back('{addr: 5'd3, data: 32'h33});
        load_hazerd_stall = 1'b1;
        ex_result = 32'h22;
        #1;
        chk("stl_addr_ex_pre", 32'(fwd.rd_addr_ex), 32'd2);
        step();
        load_hazerd_stall = 1'b0;
        ex_result = '0;
        #1;
        chk("stl_bubble_en",   32'(fwd.rd_en_ex),     32'd0);
        chk("stl_bubble_addr", 32'(fwd.rd_addr_ex),   32'd0);
        chk("stl_bubble_flag", 32'(fwd.ex_load_flag), 32'd0);
        chk("stl_mem_addr",    32'(fwd.rd_addr_mem),  32'd2);
        chk("stl_mem_data",    fwd.rd_data_mem,       32'h22);
        step();
        idle_id();
        ex_result = 32'h33;
        #1;
        chk("stl_x3_en_ex",   32'(fwd.rd_en_ex),   32'd1);
        chk("stl_x3_addr_ex", 32'(fwd.rd_addr_ex), 32'd3);
        chk("stl_mem_bubble", 32'(fwd.rd_en_mem),  32'd0);
        check_wb("stl_x2");
        step();
        ex_result = '0;
        #1;
        chk("stl_x3_mem_data", fwd.rd_data_mem, 32'h33);
        step();
        #1;
        check_wb("stl_x3");

        // Hold with all three slots full; flush during hold is ignored
        issue(5'd10, 5'b00000);
        sb.push_back('{addr: 5'd10, data: 32'hC0});
        step();
        issue(5'd11, 5'b00000);
        sb.push_back('{addr: 5'd11, data: 32'hD0});
        ex_result = 32'hC0;
        step();
        issue(5'd12, 5'b00000);
        sb.push_back('{addr: 5'd12, data: 32'hE0});
        ex_result = 32'hD0;
        step();
        idle_id();
        ex_result   = 32'hE0;
        hold        = 1'b1;
        id_rs2_addr = 5'd10;
        #1;
        check_wb("hld_x10");
        for (int k = 0; k < 3; k++) begin
            step();
            flush_ex = (k == 0);
            #1;
            chk("hld_en_ex",    32'(fwd.rd_en_ex),    32'd1);
            chk("hld_addr_ex",  32'(fwd.rd_addr_ex),  32'd12);
            chk("hld_addr_mem", 32'(fwd.rd_addr_mem), 32'd11);
            chk("hld_data_mem", fwd.rd_data_mem,      32'hD0);
            chk("hld_addr_wb",  32'(fwd.rd_addr_wb),  32'd10);
            chk("hld_data_wb",  fwd.rd_data_wb,       32'hC0);
`ifdef FWD_SOURCE_WB_BYPASS_EN
            chk("hld_rf_x10", rs2_data_id, 32'hC0);
`else
            chk("hld_rf_x10", rs2_data_id, 32'd0);
`endif
        end
        hold     = 1'b0;
        flush_ex = 1'b0;
        step();
        ex_result = '0;
        #1;
        chk("hld_rf_x10_after", rs2_data_id, 32'hC0);
        chk("hld_ex_after",     32'(fwd.rd_en_ex), 32'd0);
        check_wb("hld_x11");
        step();
        #1;
        check_wb("hld_x12");

        // Back-to-back writes to x9 and WB-cycle read
        issue(5'd9, 5'b00000);
        sb.push_back('{addr: 5'd9, data: 32'h1111});
        step();
        sb.push_back('{addr: 5'd9, data: 32'h9999});
        ex_result = 32'h1111;
        step();
        idle_id();
        ex_result = 32'h9999;
        step();
        ex_result   = '0;
        id_rs1_addr = 5'd9;
        #1;
        check_wb("b2b_first");
        step();
        #1;
        check_wb("b2b_second");
`ifdef FWD_SOURCE_WB_BYPASS_EN
        chk("byp_rf_x9", rs1_data_id, 32'h9999);
`else
        chk("byp_rf_x9", rs1_data_id, 32'h1111);
`endif
        step();
        #1;
        chk("b2b_rf_x9", rs1_data_id, 32'h9999);

        // x0 destination (as an LW) never valid and never written
        issue(5'd0, 5'b00100);
        step();
        idle_id();
        ex_result = 32'h200;
        #1;
        chk("x0_en_ex",   32'(fwd.rd_en_ex),     32'd0);
        chk("x0_flag_ex", 32'(fwd.ex_load_flag), 32'h04);
        step();
        ex_result = '0;
        mem_rdata = 32'hDEAD;
        #1;
        chk("x0_en_mem",   32'(fwd.rd_en_mem), 32'd0);
        chk("x0_data_mem", fwd.rd_data_mem,    32'hDEAD);
        step();
        mem_rdata = '0;
        id_rs1_addr = 5'd0;
        #1;
        chk("x0_en_wb",   32'(fwd.rd_en_wb), 32'd0);
        chk("x0_data_wb", fwd.rd_data_wb,    32'hDEAD);
        step();
        #1;
        chk("x0_rf", rs1_data_id, 32'd0);

        // Asynchronous reset mid-operation
        issue(5'd6, 5'b00000);
        step();
        idle_id();
        ex_result = 32'h77;
        step();
        #2;
        rst_n = 1'b0;
        id_rs1_addr = 5'd5;
        id_rs2_addr = 5'd9;
        #1;
        chk("arst_en_ex",    32'(fwd.rd_en_ex),   32'd0);
        chk("arst_en_mem",   32'(fwd.rd_en_mem),  32'd0);
        chk("arst_addr_mem", 32'(fwd.rd_addr_mem), 32'd0);
        chk("arst_data_mem", fwd.rd_data_mem,     32'd0);
        chk("arst_rf_x5",    rs1_data_id,         32'd0);
        chk("arst_rf_x9",    rs2_data_id,         32'd0);
        chk("sb_drained",    32'(sb.size()),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
